crgu_mc: RTL

CRGU_MC -- requirements
Module: crgu_mc

---
 rtl/crgu_mc.sv | 129 ++++++++++++
 1 files changed

// File: rtl/crgu_mc.sv
// Multi-channel derived-clock/reset generator: each channel divides hclk by a
// programmable factor, sequences its own reset and swaps factors only on period boundaries.
module crgu_mc #(
    parameter int NCH        = 4,
    parameter int DIV_WID    = 4,
    parameter int RST_PULSES = 2
) (
    input  logic                   hclk,
    input  logic                   hreset,
    input  logic [NCH-1:0]         ch_en,
    input  logic [NCH*DIV_WID-1:0] div_factor,
    input  logic [NCH-1:0]         div_upd,
    output logic [NCH-1:0]         upd_ack,
    output logic [NCH-1:0]         clk_div,
    output logic [NCH-1:0]         clken,
    output logic [NCH-1:0]         ch_rstn,
    output logic [NCH-1:0]         ch_busy
);

    typedef enum logic [1:0] {IDLE, RST, RUN} state_t;

    localparam int PW = (RST_PULSES < 2) ? 1 : $clog2(RST_PULSES);

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        state_t               state_q, state_d;
        logic [DIV_WID-1:0]   f_q, f_d, sh_q, sh_d, cnt_q, cnt_d;
        logic [DIV_WID-1:0]   fe, fe_n, fac;
        logic [PW-1:0]        pcnt_q, pcnt_d;
        logic                 busy_q, busy_d, ack_q, ack_d;
        logic                 div_q, div_d, rstn_q, rstn_d;
        logic                 en, upd, tick;

        assign en   = ch_en[g];
        assign upd  = div_upd[g];
        assign fac  = div_factor[g*DIV_WID +: DIV_WID];
        assign fe   = (f_q == '0) ? DIV_WID'(1) : f_q;
        assign tick = (state_q != IDLE) && (cnt_q == fe - DIV_WID'(1));

        always_ff @(posedge hclk or posedge hreset) begin
            if (hreset) begin
                state_q <= IDLE;
                f_q     <= DIV_WID'(1);
                sh_q    <= '0;
                cnt_q   <= '0;
                pcnt_q  <= '0;
                busy_q  <= 1'b0;
                ack_q   <= 1'b0;
                div_q   <= 1'b0;
                rstn_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                f_q     <= f_d;
                sh_q    <= sh_d;
                cnt_q   <= cnt_d;
                pcnt_q  <= pcnt_d;
                busy_q  <= busy_d;
                ack_q   <= ack_d;
                div_q   <= div_d;
                rstn_q  <= rstn_d;
            end
        end

        always_comb begin
            state_d = state_q;
            f_d     = f_q;
            sh_d    = sh_q;
            cnt_d   = cnt_q;
            pcnt_d  = pcnt_q;
            busy_d  = busy_q;
            ack_d   = 1'b0;
            rstn_d  = rstn_q;
            case (state_q)
                IDLE: begin
                    cnt_d  = '0;
                    pcnt_d = '0;
                    busy_d = 1'b0;
                    rstn_d = 1'b0;
                    if (upd) begin
                        f_d   = fac;
                        ack_d = 1'b1;
                    end
                    if (en) state_d = RST;
                end
                default: begin
                    if (!en) begin
                        // Disabling drops any pending factor silently.
                        state_d = IDLE;
                        cnt_d   = '0;
                        pcnt_d  = '0;
                        busy_d  = 1'b0;
                        rstn_d  = 1'b0;
                    end else begin
                        cnt_d = tick ? '0 : cnt_q + DIV_WID'(1);
                        if (upd) begin
                            sh_d   = fac;
                            busy_d = 1'b1;
                        end
                        if (tick) begin
                            if (upd || busy_q) begin
                                f_d    = upd ? fac : sh_q;
                                busy_d = 1'b0;
                                ack_d  = 1'b1;
                            end
                            if (state_q == RST) begin
                                if (pcnt_q == PW'(RST_PULSES - 1)) begin
                                    state_d = RUN;
                                    rstn_d  = 1'b1;
                                end else begin
                                    pcnt_d = pcnt_q + PW'(1);
                                end
                            end
                        end
                    end
                end
            endcase
        end

        // High for the last floor(Fe/2) counts of the period; never high when Fe = 1.
        assign fe_n  = (f_d == '0) ? DIV_WID'(1) : f_d;
        assign div_d = (state_d != IDLE) && (cnt_d >= fe_n - (fe_n >> 1));

        assign upd_ack[g] = ack_q;
        assign clk_div[g] = div_q;
        assign clken[g]   = tick;
        assign ch_rstn[g] = rstn_q;
        assign ch_busy[g] = busy_q;
    end

endmodule
